image_buffer_loader: RTL and testbench
======================================

# image_buffer_loader

Upstream stage of the image-reordering accelerator. Accepts a byte-wide pixel stream with a valid/ready handshake, packs four pixels per 32-bit word and writes one full image into the shared SRAM buffer region through the buffer port (buffer_A1/buffer_I1/buffer_WEB1). It raises image_buffer_valid when an image is resident, then holds until the hash stage reports hash_calc_done. It repeats this for num_images images.

## Interface
- BUF_BASE, 0: first SRAM word address of the image buffer region.
- WORDS_PER_IMAGE, 1024: 32-bit words per image (4×WORDS_PER_IMAGE pixels). Legal range is 1..4096-BUF_BASE.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a run. Sampled only in IDLE.
- num_images  in  9  number of images in the run. Sampled on start.
- pix_valid  in  1  pixel stream valid.
- pix_data  in  8  pixel byte.
- pix_ready  out  1  loader can accept a pixel.
- hash_calc_done  in  1  hash stage has finished with the current image.
- buffer_A1  out  12  SRAM word address.
- buffer_I1  out  32  SRAM write data.
- buffer_WEB1  out  1  write enable, active-low (0 = write).
- image_buffer_valid  out  1  the full current image is in SRAM.
- image_index  out  9  index of the image being loaded or held.
- load_done  out  1  one-cycle pulse after the last image is released.

## Operation
- States: IDLE, FILL, FLUSH, FULL.
- **IDLE**
  - pix_ready=0, buffer_WEB1=1, image_index=0.
  - start with num_images≠0 latches num_images and moves to FILL.
  - start with num_images=0 is ignored.
- **FILL**
  - pix_ready=1. A pixel is accepted when pix_valid && pix_ready.
  - A 2-bit byte counter tracks position in the word. Byte k goes to bits [8k+7:8k] (little-endian).
  - On the 4th accepted byte, the packed word is written to BUF_BASE+word_idx and word_idx increments.
  - When the accepted byte completes word WORDS_PER_IMAGE-1, move to FLUSH.
- **FLUSH**
  - pix_ready=0. The final word write is on the bus this cycle.
  - Unconditionally moves to FULL.
- **FULL**
  - image_buffer_valid=1, pix_ready=0, buffer_WEB1=1.
  - On hash_calc_done, clear image_buffer_valid, the byte counter and word_idx.
  - If image_index<num_images-1: increment image_index and return to FILL.
  - Otherwise: pulse load_done and return to IDLE.
- hash_calc_done is ignored outside FULL.
- start is ignored outside IDLE.
- Arithmetic:
  - word_idx is 12 bits. Address = BUF_BASE+word_idx, truncated to 12 bits. Wrap cannot occur for legal parameters.
  - image_index comparison uses 9-bit unsigned arithmetic on the latched num_images.
- Reset (any time, including mid-image): return to IDLE and clear all counters. The partially loaded image is abandoned; SRAM contents are undefined.

## Timing
- Reset values: pix_ready=0, buffer_A1=0, buffer_I1=0, buffer_WEB1=1, image_buffer_valid=0, image_index=0, load_done=0.
- All outputs are registered except pix_ready, which is decoded from the state register.
- Write timing:
  - The 4th byte of a word is accepted in cycle N.
  - buffer_A1/buffer_I1 are valid with buffer_WEB1=0 in cycle N+1, for exactly one cycle.
  - buffer_WEB1=1 in all other cycles.
- With pix_valid held high, a write occurs every 4 cycles.
- End-of-image timing:
  - The last byte is accepted in cycle N.
  - Cycle N+1 is FLUSH and carries the last write.
  - image_buffer_valid rises in cycle N+2.
- Release timing:
  - hash_calc_done is sampled high in FULL in cycle M.
  - image_buffer_valid=0 and pix_ready=1 (next image) in cycle M+1.
  - For the last image, load_done=1 in cycle M+1 only.
- Stalls: pix_valid low pauses packing with no state change and no write.

## Structure
- Shared package image_pkg:
  - constants ADDR_W=12, DATA_W=32, PIX_W=8, IMG_IDX_W=9;
  - typedef loader_state_t (IDLE, FILL, FLUSH, FULL).
- Sub-module pixel_packer: byte counter, shift/pack register, word_ready pulse. The top module holds the FSM, address counter and image counter.

## Test plan
- **Single small image:** WORDS_PER_IMAGE=4, num_images=1, bytes 0x00..0x0F streamed back-to-back.
  - Writes 0x03020100@0, 0x07060504@1, 0x0B0A0908@2, 0x0F0E0D0C@3.
  - image_buffer_valid rises 2 cycles after the last byte.
  - hash_calc_done → load_done pulse, then IDLE.
- **Multi-image:** num_images=3.
  - image_index steps 0,1,2.
  - Each image rewrites addresses BUF_BASE..BUF_BASE+3.
  - load_done fires only after the third hash_calc_done.
- **Bubbles:** pix_valid toggled randomly.
  - Written words and addresses are identical to the gap-free run.
  - No write occurs while pix_valid=0.
- **Backpressure and ignored controls:**
  - In FULL, pix_ready=0 and pix_valid=1 is held: no pixels are consumed.
  - start pulses in FILL/FULL have no effect.
  - hash_calc_done in FILL has no effect.
- **Reset mid-image:** reset_n pulled low after 6 bytes.
  - All outputs return to reset values asynchronously.
  - The next start reloads from word 0, byte 0.
- **Edge parameters:**
  - num_images=0 with start: stays IDLE.
  - BUF_BASE=4092, WORDS_PER_IMAGE=4: addresses 4092..4095, no wrap.

Source files
------------

// File: rtl/image_pkg.sv
// Shared types and widths for the image-buffer loader and its pixel packer.
package image_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int PIX_W     = 8;
    localparam int IMG_IDX_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH,
        FULL
    } loader_state_t;

endpackage

// File: rtl/pixel_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_ready flags the 4th byte.
module pixel_packer
    import image_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [PIX_W-1:0]  pix_data,
    output logic [DATA_W-1:0] word_data,
    output logic              word_ready
);

    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [DATA_W-PIX_W-1:0] pack_q, pack_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        pack_d     = pack_q;
        if (clear) begin
            byte_cnt_d = '0;
        end else if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    pack_d[7:0]   = pix_data;
                2'd1:    pack_d[15:8]  = pix_data;
                2'd2:    pack_d[23:16] = pix_data;
                default: pack_d        = pack_q;
            endcase
        end
    end

    // The 4th byte is merged combinationally so the word is complete in the accept cycle.
    assign word_ready = accept && !clear && (byte_cnt_q == 2'd3);
    assign word_data  = {pix_data, pack_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        pack_q <= pack_d;
    end

endmodule

// File: rtl/image_buffer_loader.sv
// Streams pixels into the SRAM image buffer one image at a time, handing each to the hash stage.
module image_buffer_loader
    import image_pkg::*;
#(
    parameter int BUF_BASE        = 0,
    parameter int WORDS_PER_IMAGE = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [IMG_IDX_W-1:0] num_images,
    input  logic                 pix_valid,
    input  logic [PIX_W-1:0]     pix_data,
    output logic                 pix_ready,
    input  logic                 hash_calc_done,
    output logic [ADDR_W-1:0]    buffer_A1,
    output logic [DATA_W-1:0]    buffer_I1,
    output logic                 buffer_WEB1,
    output logic                 image_buffer_valid,
    output logic [IMG_IDX_W-1:0] image_index,
    output logic                 load_done
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BUF_BASE);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS_PER_IMAGE - 1);

    loader_state_t        state_q, state_d;
    logic [ADDR_W-1:0]    word_idx_q, word_idx_d;
    logic [IMG_IDX_W-1:0] img_idx_q, img_idx_d;
    logic [IMG_IDX_W-1:0] num_img_q, num_img_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 web_q, web_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 clear;
    logic                 accept;
    logic [DATA_W-1:0]    word_data;
    logic                 word_ready;

    assign pix_ready = (state_q == FILL);
    assign accept    = pix_valid && pix_ready;

    pixel_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .accept     (accept),
        .pix_data   (pix_data),
        .word_data  (word_data),
        .word_ready (word_ready)
    );

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        img_idx_d  = img_idx_q;
        num_img_d  = num_img_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        web_d      = 1'b1;
        valid_d    = valid_q;
        done_d     = 1'b0;
        clear      = 1'b0;
        case (state_q)
            IDLE: begin
                img_idx_d = '0;
                if (start && (num_images != '0)) begin
                    num_img_d  = num_images;
                    word_idx_d = '0;
                    clear      = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (word_ready) begin
                    web_d      = 1'b0;
                    addr_d     = BASE_ADDR + word_idx_q;
                    wdata_d    = word_data;
                    word_idx_d = word_idx_q + 1'b1;
                    if (word_idx_q == LAST_WORD) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                valid_d = 1'b1;
                state_d = FULL;
            end
            FULL: begin
                if (hash_calc_done) begin
                    valid_d    = 1'b0;
                    word_idx_d = '0;
                    clear      = 1'b1;
                    // 9-bit wrap on num_img_q-1 is harmless: num_img_q is never zero here.
                    if (img_idx_q < (num_img_q - 1'b1)) begin
                        img_idx_d = img_idx_q + 1'b1;
                        state_d   = FILL;
                    end else begin
                        img_idx_d = '0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            img_idx_q  <= '0;
            num_img_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            web_q      <= 1'b1;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            img_idx_q  <= img_idx_d;
            num_img_q  <= num_img_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            web_q      <= web_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign buffer_A1          = addr_q;
    assign buffer_I1          = wdata_q;
    assign buffer_WEB1        = web_q;
    assign image_buffer_valid = valid_q;
    assign image_index        = img_idx_q;
    assign load_done          = done_q;

endmodule

// File: tb/tb_image_buffer_loader.sv
// Randomized bench for image_buffer_loader: two instances (base 0 and base 4092, 4 words/image).
module tb_image_buffer_loader;

    logic       clk = 1'b0;
    logic       reset_n, start, pix_valid, hash_calc_done;
    logic [8:0] num_images;
    logic [7:0] pix_data;

    logic        pix_ready_a, web_a, valid_a, done_a;
    logic [11:0] a1_a;
    logic [31:0] i1_a;
    logic [8:0]  idx_a;
    logic        pix_ready_b, web_b, valid_b, done_b;
    logic [11:0] a1_b;
    logic [31:0] i1_b;
    logic [8:0]  idx_b;

    int n_cmp = 0;
    int n_bad = 0;
    int stray = 0;
    logic        acc_edge = 1'b0;
    logic [7:0]  img [16];
    logic [43:0] wq_a [$];
    logic [43:0] wq_b [$];

    localparam logic [56:0] RST_VAL = {1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 9'd0, 1'b0};

    image_buffer_loader #(.BUF_BASE(0), .WORDS_PER_IMAGE(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .num_images(num_images),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready_a),
        .hash_calc_done(hash_calc_done), .buffer_A1(a1_a), .buffer_I1(i1_a),
        .buffer_WEB1(web_a), .image_buffer_valid(valid_a), .image_index(idx_a),
        .load_done(done_a)
    );

    image_buffer_loader #(.BUF_BASE(4092), .WORDS_PER_IMAGE(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .num_images(num_images),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready_b),
        .hash_calc_done(hash_calc_done), .buffer_A1(a1_b), .buffer_I1(i1_b),
        .buffer_WEB1(web_b), .image_buffer_valid(valid_b), .image_index(idx_b),
        .load_done(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) acc_edge <= pix_valid && pix_ready_a;

    always @(negedge clk) begin
        if (reset_n) begin
            if (!web_a) begin
                wq_a.push_back({a1_a, i1_a});
                if (!acc_edge) stray++;
            end
            if (!web_b) wq_b.push_back({a1_b, i1_b});
        end
    end

    function automatic logic [56:0] outs_a();
        return {pix_ready_a, a1_a, i1_a, web_a, valid_a, idx_a, done_a};
    endfunction

    function automatic logic [56:0] outs_b();
        return {pix_ready_b, a1_b, i1_b, web_b, valid_b, idx_b, done_b};
    endfunction

    task automatic do_start(input logic [8:0] n);
        start = 1'b1;
        num_images = n;
        @(negedge clk);
        start = 1'b0;
        num_images = 9'($urandom);
    endtask

    // Streams nbytes random pixels; a full image also gets its write/timing checks.
    task automatic feed(input int nbytes, input bit bubbles, input bit noise);
        int i = 0;
        int guard = 0;
        bit acc;
        logic [31:0] exp_w;
        for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
        wq_a.delete();
        wq_b.delete();
        stray = 0;
        while (i < nbytes && guard < 500) begin
            pix_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_data = img[i];
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                num_images = 9'd7;
                hash_calc_done = 1'($urandom_range(0, 1));
            end
            acc = pix_valid && pix_ready_a;
            @(negedge clk);
            if (acc) i++;
            guard++;
        end
        pix_valid = 1'b0;
        start = 1'b0;
        hash_calc_done = 1'b0;
        n_cmp++;
        if (i != nbytes) begin
            n_bad++;
            $display("FAIL feed_progress: accepted %0d bytes, required %0d", i, nbytes);
        end
        if (nbytes == 16) begin
            n_cmp++;
            if ({web_a, valid_a, pix_ready_a, a1_a} !== {1'b0, 1'b0, 1'b0, 12'd3}) begin
                n_bad++;
                $display("FAIL flush_cycle: web/valid/ready/addr %b%b%b %0d, required 000 3",
                         web_a, valid_a, pix_ready_a, a1_a);
            end
            @(negedge clk);
            n_cmp++;
            if ({web_a, valid_a, pix_ready_a, valid_b} !== 4'b1101) begin
                n_bad++;
                $display("FAIL valid_rise: web/valid/ready/valid_b %b%b%b%b, required 1101",
                         web_a, valid_a, pix_ready_a, valid_b);
            end
            n_cmp++;
            if (wq_a.size() != 4 || wq_b.size() != 4) begin
                n_bad++;
                $display("FAIL write_count: %0d/%0d writes, required 4/4", wq_a.size(), wq_b.size());
            end else begin
                for (int k = 0; k < 4; k++) begin
                    exp_w = {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
                    n_cmp++;
                    if (wq_a[k] !== {12'(k), exp_w}) begin
                        n_bad++;
                        $display("FAIL write_a[%0d]: got %h, required %h", k, wq_a[k], {12'(k), exp_w});
                    end
                    n_cmp++;
                    if (wq_b[k] !== {12'(4092 + k), exp_w}) begin
                        n_bad++;
                        $display("FAIL write_b[%0d]: got %h, required %h", k, wq_b[k], {12'(4092 + k), exp_w});
                    end
                end
            end
            n_cmp++;
            if (stray != 0) begin
                n_bad++;
                $display("FAIL stray_write: %0d writes without a preceding accept, required 0", stray);
            end
        end
    endtask

    task automatic release_img(input bit last, input logic [8:0] next_idx);
        hash_calc_done = 1'b1;
        @(negedge clk);
        hash_calc_done = 1'b0;
        n_cmp++;
        if ({valid_a, pix_ready_a, done_a, idx_a} !== {1'b0, !last, last, last ? 9'd0 : next_idx}) begin
            n_bad++;
            $display("FAIL release: valid/ready/done/idx %b%b%b %0d, required 0%b%b %0d",
                     valid_a, pix_ready_a, done_a, idx_a, !last, last, last ? 9'd0 : next_idx);
        end
        if (last) begin
            @(negedge clk);
            n_cmp++;
            if ({done_a, pix_ready_a} !== 2'b00) begin
                n_bad++;
                $display("FAIL done_pulse: done/ready %b%b, required 00", done_a, pix_ready_a);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (outs_a() !== RST_VAL || outs_b() !== RST_VAL) begin
            n_bad++;
            $display("FAIL reset_values: got %h / %h, required %h", outs_a(), outs_b(), RST_VAL);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_image();
        do_start(9'd1);
        n_cmp++;
        if ({pix_ready_a, idx_a} !== {1'b1, 9'd0}) begin
            n_bad++;
            $display("FAIL start_fill: ready/idx %b %0d, required 1 0", pix_ready_a, idx_a);
        end
        feed(16, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({valid_a, pix_ready_a} !== 2'b10) begin
            n_bad++;
            $display("FAIL full_hold: valid/ready %b%b, required 10", valid_a, pix_ready_a);
        end
        release_img(1'b1, 9'd0);
    endtask

    task automatic test_multi_image();
        do_start(9'd3);
        for (int m = 0; m < 3; m++) begin
            n_cmp++;
            if (idx_a !== 9'(m)) begin
                n_bad++;
                $display("FAIL image_index: got %0d, required %0d", idx_a, m);
            end
            feed(16, 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_img(m == 2, 9'(m + 1));
        end
    endtask

    task automatic test_bubbles();
        do_start(9'd2);
        feed(16, 1'b1, 1'b0);
        release_img(1'b0, 9'd1);
        feed(16, 1'b1, 1'b0);
        release_img(1'b1, 9'd0);
    endtask

    task automatic test_ignored_controls();
        do_start(9'd1);
        feed(16, 1'b0, 1'b1);
        pix_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            pix_data = 8'($urandom);
            start = c[0];
            num_images = 9'd5;
            @(negedge clk);
            n_cmp++;
            if ({pix_ready_a, valid_a} !== 2'b01) begin
                n_bad++;
                $display("FAIL backpressure: ready/valid %b%b, required 01", pix_ready_a, valid_a);
            end
        end
        pix_valid = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (wq_a.size() != 4) begin
            n_bad++;
            $display("FAIL full_no_write: %0d writes, required 4", wq_a.size());
        end
        release_img(1'b1, 9'd0);
    endtask

    task automatic test_reset_mid_image();
        do_start(9'd1);
        feed(6, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (outs_a() !== RST_VAL || outs_b() !== RST_VAL) begin
            n_bad++;
            $display("FAIL async_reset: got %h / %h, required %h", outs_a(), outs_b(), RST_VAL);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_start(9'd1);
        feed(16, 1'b0, 1'b0);
        release_img(1'b1, 9'd0);
    endtask

    task automatic test_zero_images();
        wq_a.delete();
        do_start(9'd0);
        for (int c = 0; c < 4; c++) begin
            pix_valid = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({pix_ready_a, valid_a, idx_a} !== 11'd0) begin
                n_bad++;
                $display("FAIL zero_images: ready/valid/idx %b%b %0d, required 00 0",
                         pix_ready_a, valid_a, idx_a);
            end
        end
        pix_valid = 1'b0;
        n_cmp++;
        if (wq_a.size() != 0) begin
            n_bad++;
            $display("FAIL zero_images_write: %0d writes, required 0", wq_a.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        num_images = '0;
        pix_valid = 1'b0;
        pix_data = '0;
        hash_calc_done = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_image();
        test_multi_image();
        test_bubbles();
        test_ignored_controls();
        test_reset_mid_image();
        test_zero_images();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
